// File: rtl/eth_pcm_receiver_pkg.sv
// Shared constants and state types for the audio-over-Ethernet link.
// The transmit side uses the same frame layout constants.
package eth_pcm_receiver_pkg;

    localparam int HDR_LEN     = 14;
    localparam int NCHAN       = 8;
    localparam int NFRAMES     = 32;
    localparam int PAYLOAD_LEN = NFRAMES * NCHAN * 2;
    localparam int ETH_HI_OFS  = 12;
    localparam int ETH_LO_OFS  = 13;
    localparam int ADDR_W      = 10;

    localparam logic [15:0] ETHERTYPE = 16'h88B5;

    localparam logic [9:0] HI_IDX   = 10'(ETH_HI_OFS);
    localparam logic [9:0] LO_IDX   = 10'(ETH_LO_OFS);
    localparam logic [9:0] HDR_IDX  = 10'(HDR_LEN);
    localparam logic [9:0] LAST_IDX = 10'(HDR_LEN + PAYLOAD_LEN - 1);

    typedef enum logic [2:0] {
        W_IDLE,
        W_HDR,
        W_PAY,
        W_TAIL,
        W_DROP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DONE
    } rd_state_t;

    function automatic logic [15:0] pack_sample(logic [7:0] hi, logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/eth_pcm_receiver_if.sv
// Byte-stream input and PCM/status output bundle of the receiver.
interface eth_pcm_receiver_if;

    logic        rx_stb;
    logic [7:0]  rx_data;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_err;
    logic        pcm_stb;
    logic        pcm_valid;
    logic [2:0]  pcm_chan;
    logic [15:0] pcm_data;
    logic [15:0] frames_ok;
    logic [15:0] frames_drop;
    logic [15:0] underruns;

    modport master (
        output rx_stb, rx_data, rx_sof, rx_eof, rx_err, pcm_stb,
        input  pcm_valid, pcm_chan, pcm_data,
        input  frames_ok, frames_drop, underruns
    );

    modport slave (
        input  rx_stb, rx_data, rx_sof, rx_eof, rx_err, pcm_stb,
        output pcm_valid, pcm_chan, pcm_data,
        output frames_ok, frames_drop, underruns
    );

endinterface

// File: rtl/eth_pcm_receiver_bram.sv
// 8-bit simple dual-port block RAM, 1024 deep, registered read port.
module eth_pcm_receiver_bram
    import eth_pcm_receiver_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/eth_pcm_receiver.sv
// Ethernet PCM receiver: header check, ping-pong payload store and
// per-strobe playout of one 8-channel frame.
module eth_pcm_receiver
    import eth_pcm_receiver_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    eth_pcm_receiver_if.slave bus
);

    wr_state_t   wr_state, wr_state_nx;
    logic [9:0]  byte_cnt, byte_cnt_nx;
    logic        wr_bank;
    logic        commit, drop_inc, we;
    logic        start, idle_eff, wr_bank_eff;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [7:0]  rdata;

    rd_state_t   rd_state, rd_state_nx;
    logic [4:0]  phase, phase_nx;
    logic        have, have_nx;
    logic [7:0]  lo, lo_nx;
    logic [4:0]  rd_frame, rd_frame_nx;
    logic        rd_bank, rd_bank_nx;
    logic        rel, under_inc;
    logic        valid_q, valid_nx;
    logic [2:0]  chan_q, chan_nx;
    logic [15:0] data_q, data_nx;

    logic [1:0]  full, full_nx;
    logic [15:0] ok_cnt, drop_cnt, under_cnt;

    assign start = bus.rx_stb & bus.rx_sof;
    assign waddr = {wr_bank, 9'(byte_cnt - HDR_IDX)};
    assign raddr = {rd_bank, rd_frame,
                    (rd_state == R_FETCH) ? phase[3:0] : 4'd0};

    always_comb begin
        wr_state_nx = wr_state;
        byte_cnt_nx = byte_cnt;
        commit      = 1'b0;
        drop_inc    = 1'b0;
        we          = 1'b0;
        idle_eff    = (wr_state == W_IDLE);
        if (wr_state != W_IDLE) begin
            if (bus.rx_eof) begin
                commit      = (wr_state == W_TAIL) && !bus.rx_err;
                drop_inc    = !commit;
                wr_state_nx = W_IDLE;
                idle_eff    = 1'b1;
            end else if (start) begin
                drop_inc    = 1'b1;
                wr_state_nx = W_IDLE;
                idle_eff    = 1'b1;
            end else if (bus.rx_stb) begin
                unique case (wr_state)
                    W_HDR: begin
                        byte_cnt_nx = byte_cnt + 10'd1;
                        if (byte_cnt == HI_IDX &&
                            bus.rx_data != ETHERTYPE[15:8])
                            wr_state_nx = W_DROP;
                        else if (byte_cnt == LO_IDX)
                            wr_state_nx = (bus.rx_data == ETHERTYPE[7:0])
                                          ? W_PAY : W_DROP;
                    end
                    W_PAY: begin
                        we          = 1'b1;
                        byte_cnt_nx = byte_cnt + 10'd1;
                        if (byte_cnt == LAST_IDX)
                            wr_state_nx = W_TAIL;
                    end
                    default: ;
                endcase
            end
        end
        // a commit in this cycle already moved the writer to the other bank
        wr_bank_eff = commit ? ~wr_bank : wr_bank;
        if (idle_eff && start) begin
            if (full[wr_bank_eff]) begin
                wr_state_nx = W_DROP;
            end else begin
                wr_state_nx = W_HDR;
                byte_cnt_nx = 10'd1;
            end
        end
    end

    always_comb begin
        rd_state_nx = rd_state;
        phase_nx    = phase;
        have_nx     = have;
        lo_nx       = lo;
        rd_frame_nx = rd_frame;
        rd_bank_nx  = rd_bank;
        rel         = 1'b0;
        under_inc   = 1'b0;
        valid_nx    = 1'b0;
        chan_nx     = chan_q;
        data_nx     = data_q;
        unique case (rd_state)
            R_IDLE: begin
                if (bus.pcm_stb) begin
                    rd_state_nx = R_FETCH;
                    phase_nx    = 5'd1;
                    have_nx     = full[rd_bank];
                    under_inc   = !full[rd_bank];
                end
            end
            R_FETCH: begin
                phase_nx = phase + 5'd1;
                if (phase[0]) begin
                    lo_nx = rdata;
                end else begin
                    valid_nx = 1'b1;
                    chan_nx  = phase[3:1] - 3'd1;
                    data_nx  = have ? pack_sample(rdata, lo) : 16'd0;
                    if (phase[4]) begin
                        rd_state_nx = R_DONE;
                        if (have) begin
                            rd_frame_nx = rd_frame + 5'd1;
                            if (rd_frame == 5'd31) begin
                                rel        = 1'b1;
                                rd_bank_nx = ~rd_bank;
                            end
                        end
                    end
                end
            end
            R_DONE: rd_state_nx = R_IDLE;
            default: rd_state_nx = R_IDLE;
        endcase
    end

    always_comb begin
        full_nx = full;
        if (rel)
            full_nx[rd_bank] = 1'b0;
        if (commit)
            full_nx[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= W_IDLE;
            byte_cnt <= '0;
            wr_bank  <= 1'b0;
            full     <= '0;
            ok_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            wr_state <= wr_state_nx;
            byte_cnt <= byte_cnt_nx;
            wr_bank  <= wr_bank_eff;
            full     <= full_nx;
            if (commit)
                ok_cnt <= ok_cnt + 16'd1;
            if (drop_inc)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state  <= R_IDLE;
            phase     <= '0;
            have      <= 1'b0;
            lo        <= '0;
            rd_frame  <= '0;
            rd_bank   <= 1'b0;
            valid_q   <= 1'b0;
            chan_q    <= '0;
            data_q    <= '0;
            under_cnt <= '0;
        end else begin
            rd_state <= rd_state_nx;
            phase    <= phase_nx;
            have     <= have_nx;
            lo       <= lo_nx;
            rd_frame <= rd_frame_nx;
            rd_bank  <= rd_bank_nx;
            valid_q  <= valid_nx;
            chan_q   <= chan_nx;
            data_q   <= data_nx;
            if (under_inc)
                under_cnt <= under_cnt + 16'd1;
        end
    end

    eth_pcm_receiver_bram u_bram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.rx_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign bus.pcm_valid   = valid_q;
    assign bus.pcm_chan    = chan_q;
    assign bus.pcm_data    = data_q;
    assign bus.frames_ok   = ok_cnt;
    assign bus.frames_drop = drop_cnt;
    assign bus.underruns   = under_cnt;

endmodule

// File: doc/eth_pcm_receiver.md
Name: eth_pcm_receiver

Overview:
- Receive end of the audio-over-Ethernet link: accepts the byte stream of received frames and validates the header.
- Buffers each 512-byte PCM payload in a ping-pong BRAM (2 banks x 512 bytes).
- Plays samples out one PCM frame (8 channels x 16 bit) per pcm_stb, for the DAC/PDM modulator path.
- Sits between the Ethernet receiver (MAC byte output) and the audio output stage.

Parameters:
- ETHERTYPE, 16'h88B5, required value of frame bytes 12 (MSB) and 13 (LSB).
- HDR_LEN, 14, header bytes preceding the payload.
- NCHAN, 8, channels per PCM frame.
- NFRAMES, 32, PCM frames per packet; payload = NFRAMES*NCHAN*2 = 512 bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_stb  in  1  rx_data valid this cycle
- rx_data  in  8  received byte (preamble/SFD stripped; FCS bytes may follow payload)
- rx_sof  in  1  first byte of frame; only valid together with rx_stb
- rx_eof  in  1  end-of-frame pulse, at least 1 cycle after the last rx_stb
- rx_err  in  1  FCS/PHY error, valid with rx_eof
- pcm_stb  in  1  sample-rate strobe, 1 cycle
- pcm_valid  out  1  sample present on pcm_data
- pcm_chan  out  3  channel index of pcm_data
- pcm_data  out  16  sample, little-endian reassembled
- frames_ok  out  16  committed packets, wraps
- frames_drop  out  16  rejected packets, wraps
- underruns  out  16  pcm_stb with no buffered data, wraps

Behaviour:
- Reset (async, any state):
  - Both banks empty; wr_bank = rd_bank = 0; both FSMs idle.
  - All outputs 0; counters 0.
- Write FSM states: IDLE, HDR, PAY, TAIL, DROP.
- IDLE: on rx_stb & rx_sof, branch on the write bank:
  - full[wr_bank] set -> DROP.
  - Otherwise -> HDR with byte_cnt = 1.
- HDR:
  - Byte 12 must equal ETHERTYPE[15:8] and byte 13 must equal ETHERTYPE[7:0].
  - Mismatch -> DROP.
  - After byte 13 -> PAY.
- PAY:
  - Each rx_stb writes rx_data to BRAM address {wr_bank, byte_cnt-14}.
  - After payload byte 511 -> TAIL.
- TAIL: further bytes (FCS) are ignored.
- Frame end:
  - rx_eof in TAIL with !rx_err: set full[wr_bank], toggle wr_bank, frames_ok++, -> IDLE.
  - rx_eof in any other non-IDLE state, or with rx_err: frames_drop++, -> IDLE. The bank is not committed; partial data is overwritten later.
  - rx_sof while not IDLE aborts the current frame (frames_drop++) and restarts header parsing on the same byte, subject to the IDLE full check.
- DROP waits for rx_eof, then frames_drop++ once.
- Read FSM states: IDLE, FETCH, DONE.
  - pcm_stb in IDLE at cycle T:
    - If full[rd_bank]: read bytes {rd_bank, rd_frame*16 + 0..15} at cycles T+1..T+16 (BRAM latency 1 cycle).
    - Channel k: pcm_valid pulses at T+3+2k with pcm_chan = k and pcm_data = {byte 2k+1, byte 2k}.
    - If !full[rd_bank]: underruns++ and 8 zero samples emitted with the same timing.
  - After channel 7:
    - rd_frame++.
    - On rd_frame wrap 31->0: clear full[rd_bank] and toggle rd_bank.
    - -> IDLE at T+18.
  - pcm_stb while not IDLE is ignored.
- Simultaneous commit (set full) and release (clear full) of different banks in one cycle: both take effect.
- pcm_valid is 0 outside the 8 pulses. pcm_data/pcm_chan hold their last value.
- Counters saturate never; they wrap 16'hFFFF -> 0.

Decomposition:
- Shared package/include: HDR_LEN, NCHAN, NFRAMES, PAYLOAD_LEN (512), ETHERTYPE default, byte offsets 12/13. The same constants are used by the transmit side.
- Sub-modules:
  - Instantiate the existing 8-bit simple dual-port bram (10-bit address) as the ping-pong store.
  - Keep write and read FSMs in this module; no further sub-module.

Test Plan:
- Reset, then one valid 526-byte frame (payload bytes = index & 0xFF) plus 4 FCS bytes and eof, then pcm_stb -> frames_ok=1; chan0..7 = 0x0100,0x0302,...,0x0F0E at T+3..T+17 odd offsets.
- Ethertype 0x0800 frame -> frames_drop=1, no bank filled; next pcm_stb -> underruns=1, 8 zero samples.
- Three good frames without pcm_stb -> frames_ok=2, frames_drop=1; 64 pcm_stb return frames 1 and 2 data in order, 65th stb -> underruns=1.
- Frame with rx_err on eof, and frame truncated at 300 bytes -> frames_drop=2, full flags unchanged.
- Reset asserted mid-payload and mid-playout -> all outputs 0 immediately; a subsequent good frame plays from bank 0, frame 0.
- Commit of bank 1 in the same cycle bank 0 is released after frame 31 -> both flags correct; playout continues seamlessly into bank 1.
